// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution sequencer.
package branch_pkg;

    localparam int unsigned XLEN_DEF = 32;

    typedef enum logic [1:0] {
        KindBranch = 2'd0,
        KindJal    = 2'd1,
        KindJalr   = 2'd2,
        KindRsvd   = 2'd3
    } req_kind_e;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef logic [1:0] state_t;
    localparam state_t StIdle    = 2'd0;
    localparam state_t StAluReq  = 2'd1;
    localparam state_t StAluWait = 2'd2;
    localparam state_t StResolve = 2'd3;

endpackage

// File: rtl/branch_ctrl_if.sv
// Decode request, shared-ALU and resolution channels of the branch sequencer.
interface branch_ctrl_if #(
    parameter int unsigned XLEN = branch_pkg::XLEN_DEF
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_kind;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_imm;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;

    logic            alu_req;
    logic            alu_gnt;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic            alu_done;
    logic            alu_zero;
    logic            alu_carry;
    logic            alu_sign;
    logic            alu_overflow;

    logic            res_valid;
    logic            res_ready;
    logic            res_taken;
    logic [XLEN-1:0] res_target;
    logic [XLEN-1:0] res_link;
    logic            res_link_we;
    logic            res_illegal;
    logic            res_misalign;

    modport master (
        output req_valid, req_kind, req_funct3, req_pc, req_imm, req_rs1, req_rs2,
        input  req_ready,
        input  alu_req, alu_a, alu_b,
        output alu_gnt, alu_done, alu_zero, alu_carry, alu_sign, alu_overflow,
        input  res_valid, res_taken, res_target, res_link, res_link_we, res_illegal,
        input  res_misalign,
        output res_ready
    );

    modport slave (
        input  req_valid, req_kind, req_funct3, req_pc, req_imm, req_rs1, req_rs2,
        output req_ready,
        output alu_req, alu_a, alu_b,
        input  alu_gnt, alu_done, alu_zero, alu_carry, alu_sign, alu_overflow,
        output res_valid, res_taken, res_target, res_link, res_link_we, res_illegal,
        output res_misalign,
        input  res_ready
    );

endinterface

// File: rtl/branch_gen.sv
// Branch condition evaluator: maps funct3 and rs1-rs2 subtract flags to taken.
module branch_gen
    import branch_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       carry_i,
    input  logic       sign_i,
    input  logic       overflow_i,
    output logic       taken_o
);

    // carry is set when no borrow occurred, i.e. rs1 >= rs2 unsigned
    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            BEQ:     taken_o = zero_i;
            BNE:     taken_o = !zero_i;
            BLT:     taken_o = sign_i ^ overflow_i;
            BGE:     taken_o = !(sign_i ^ overflow_i);
            BLTU:    taken_o = !carry_i;
            BGEU:    taken_o = carry_i;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Multi-cycle branch/jump resolution sequencer sharing the core ALU for compares.
// Optional macro BRANCH_CTRL_MISALIGN_EN suppresses redirects to unaligned targets.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input logic         clk,
    input logic         rst,
    input logic         flush_in,
    branch_ctrl_if.slave bus
);

    localparam logic [XLEN-1:0] AlignMask = {{(XLEN-1){1'b1}}, 1'b0};

    state_t          state_q, state_d;
    req_kind_e       kind_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] pc_q, imm_q, rs1_q, rs2_q;
    logic            zero_q, carry_q, sign_q, ovf_q;

    logic            accept;
    logic            req_is_branch;
    logic            is_branch;
    logic            cond;
    logic            illegal;
    logic            taken_raw;
    logic            misalign;
    logic            taken;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] tgt;

    assign bus.req_ready = (state_q == StIdle) && !flush_in;
    assign accept        = bus.req_valid && bus.req_ready;
    assign req_is_branch = (bus.req_kind == KindBranch) || (bus.req_kind == KindRsvd);

    always_comb begin
        state_d = state_q;
        if (flush_in) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:    if (bus.req_valid) state_d = req_is_branch ? StAluReq : StResolve;
                StAluReq:  if (bus.alu_gnt) state_d = StAluWait;
                StAluWait: if (bus.alu_done) state_d = StResolve;
                StResolve: if (bus.res_ready) state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            kind_q   <= KindBranch;
            funct3_q <= 3'b000;
            pc_q     <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                kind_q   <= req_kind_e'(bus.req_kind);
                funct3_q <= bus.req_funct3;
                pc_q     <= bus.req_pc;
                imm_q    <= bus.req_imm;
                rs1_q    <= bus.req_rs1;
                rs2_q    <= bus.req_rs2;
            end
            if ((state_q == StAluWait) && bus.alu_done && !flush_in) begin
                zero_q  <= bus.alu_zero;
                carry_q <= bus.alu_carry;
                sign_q  <= bus.alu_sign;
                ovf_q   <= bus.alu_overflow;
            end
        end
    end

    branch_gen u_branch_gen (
        .funct3_i   (funct3_q),
        .zero_i     (zero_q),
        .carry_i    (carry_q),
        .sign_i     (sign_q),
        .overflow_i (ovf_q),
        .taken_o    (cond)
    );

    assign is_branch = (kind_q == KindBranch) || (kind_q == KindRsvd);
    assign illegal   = is_branch && (funct3_q[2:1] == 2'b01);
    assign taken_raw = is_branch ? (cond && !illegal) : 1'b1;
    assign link      = pc_q + XLEN'(4);
    assign tgt       = (kind_q == KindJalr) ? ((rs1_q + imm_q) & AlignMask) : (pc_q + imm_q);

`ifdef BRANCH_CTRL_MISALIGN_EN
    assign misalign = taken_raw && (tgt[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign taken = taken_raw && !misalign;

    assign bus.alu_req = (state_q == StAluReq);
    assign bus.alu_a   = rs1_q;
    assign bus.alu_b   = rs2_q;

    // Resolution fields read as zero outside RESOLVE so idle/reset outputs are clean
    assign bus.res_valid    = (state_q == StResolve);
    assign bus.res_taken    = bus.res_valid && taken;
    assign bus.res_target   = bus.res_valid ? (taken ? tgt : link) : '0;
    assign bus.res_link     = bus.res_valid ? link : '0;
    assign bus.res_link_we  = bus.res_valid && !is_branch;
    assign bus.res_illegal  = bus.res_valid && illegal;
    assign bus.res_misalign = bus.res_valid && misalign;

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Multi-cycle branch/jump resolution sequencer for the rv32i core. Accepts one control-transfer op from decode. For conditional branches it borrows the shared ALU for an rs1−rs2 compare and evaluates the condition from the returned flags. It then presents one resolution (taken, target, link value) to fetch/writeback over a valid/ready handshake. JAL/JALR resolve locally without the ALU.

Parameters:
XLEN, 32, datapath/address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_in  in  1  trap/kill; aborts any op in flight
req_valid  in  1  decode offers op
req_ready  out  1  = (state==IDLE) && !flush_in
req_kind  in  2  0 branch, 1 JAL, 2 JALR, 3 reserved (treated as branch)
req_funct3  in  3  branch condition
req_pc, req_imm, req_rs1, req_rs2  in  XLEN each  operands
alu_req  out  1  request shared ALU; held until grant
alu_gnt  in  1  grant
alu_a, alu_b  out  XLEN  latched rs1, rs2 (valid while alu_req)
alu_done  in  1  flags valid this cycle, ≥1 cycle after grant
alu_zero, alu_carry, alu_sign, alu_overflow  in  1 each  subtract flags
res_valid  out  1  resolution available
res_ready  in  1  consumer accepts
res_taken  out  1  redirect required
res_target  out  XLEN  next PC (pc+4 when not taken)
res_link  out  XLEN  pc+4
res_link_we  out  1  JAL/JALR only
res_illegal  out  1  funct3 010/011
res_misalign  out  1  see optional feature (0 when compiled out)

Behaviour:
- States: IDLE, ALU_REQ, ALU_WAIT, RESOLVE. Reset → IDLE; all outputs 0 (res_target/res_link 0).
- IDLE: on req_valid && req_ready, latch all req_* fields. Branch → ALU_REQ; JAL/JALR → RESOLVE.
- ALU_REQ: alu_req=1. On alu_gnt → ALU_WAIT, with alu_req dropped the same cycle the grant is sampled.
- ALU_WAIT: on alu_done, latch the four flags → RESOLVE. alu_done seen in any other state is ignored.
- Carry convention: alu_carry=1 iff rs1 ≥ rs2 unsigned (no borrow).
- Taken by funct3: 000 zero; 001 !zero; 100 sign^overflow; 101 !(sign^overflow); 110 !carry; 111 carry; 010/011 not taken with res_illegal=1.
- Target: branch/JAL = pc+imm; JALR = (rs1+imm) & ~1. All arithmetic is modulo 2^XLEN; wrap is silent.
- res_target = taken ? target : pc+4. JAL/JALR are always taken.
- RESOLVE: res_valid=1 and all res_* fields stable until res_ready. On res_ready → IDLE.
- Minimum latency:
  - JAL/JALR: accepted cycle N → res_valid at N+1.
  - Branch with immediate grant and alu_done at N+2 → res_valid at N+3.
- Back-to-back: a new request is accepted the cycle after the res_ready handshake; there is no same-cycle overlap.
- flush_in (any state, highest priority): next state IDLE; alu_req and res_valid drop the next cycle; no resolution is emitted.
- flush_in during ALU_WAIT: the late alu_done is discarded.
- rst mid-operation: same effect as flush, and outputs are also cleared.

Optional Feature:
BRANCH_CTRL_MISALIGN_EN
- Defined: a taken result with res_target[1:0]!=0 sets res_misalign=1, forces res_taken=0 and res_target=pc+4 (no redirect), and still completes the handshake.
- Undefined: res_misalign is tied 0 and the target is passed through unchecked.

Decomposition:
- Package branch_pkg holds:
  - XLEN default
  - req_kind enum
  - funct3 constants BEQ/BNE/BLT/BGE/BLTU/BGEU
  - FSM state enum
- Sub-module: instantiate the existing branch_gen condition evaluator on the latched flags. res_illegal is decoded in branch_ctrl.

Test Plan:
- BEQ pc=0x100, imm=0x20, rs1=rs2=5; grant immediate, alu_done next cycle with zero=1 → res_taken=1, target=0x120, link_we=0, res_valid 3 cycles after accept.
- BLTU rs1=3, rs2=7, carry=0; res_ready held low 4 cycles → res_taken=1 and all res_* stable throughout; accept the next request one cycle after the handshake.
- JALR pc=0x200, rs1=0x1003, imm=0 → res_valid next cycle, target=0x1002, link=0x204, link_we=1, alu_req never asserted.
- BGE with alu_gnt delayed 5 cycles, then flush_in in ALU_WAIT followed by a stray alu_done → no res_valid, state IDLE, req_ready=1.
- funct3=010 → res_illegal=1, res_taken=0, target=pc+4; with BRANCH_CTRL_MISALIGN_EN, JAL pc=0, imm=0x6 → res_misalign=1, target=0x4.
- pc=0xFFFFFFFC, BNE taken with imm=8 → target=0x00000004 (wrap); not-taken case gives target=0x00000000.
